// File: rtl/des_f_function.sv
// des_f_function: pipelined DES round function f(R, K).
//
// Data path: x = E(r_in) ^ subkey is registered on accept, then the eight
// S-boxes and permutation P turn x into the 32-bit f result.
//
// Build option DES_F_OUTREG_EN:
//   defined     -> two registered stages (x, then f_out); latency 2, capacity 2.
//   not defined -> f_out is driven combinationally from the x register;
//                  latency 1, capacity 1, f_out resets to P(S(0)) = 32'hD8D8DBBC.
//
// Bit numbering follows DES: bit 1 is the MSB of every bus
// (r_in[31], subkey[47], f_out[31]).
module des_f_function (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. A producer holds valid and its data steady until that edge;
  // ready may depend combinationally on the consumer's ready (in_ready follows
  // out_ready), never on valid. Data is sampled only on a transfer.

  // S-box rows, four per box (S1 row 0 first). Each 64-bit word holds the
  // 16 column entries, column 0 in the top nibble.
  localparam logic [63:0] SBOX_ROWS [0:31] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Expansion E: each 6-bit group n takes DES bits 4n-4 .. 4n+1 of R,
  // wrapping bit 0 to 32 and bit 33 to 1.
  function automatic logic [47:0] expand(input logic [31:0] r);
    expand = {r[0],    r[31:27],
              r[28:23],
              r[24:19],
              r[20:15],
              r[16:11],
              r[12:7],
              r[8:3],
              r[4:0],  r[31]};
  endfunction

  // One S-box lookup: row = {b5, b0}, column = b4..b1.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] word;
    row  = {b[5], b[0]};
    col  = b[4:1];
    word = SBOX_ROWS[{box, row}];
    // Column c sits at bits [60-4c +: 4], i.e. base 4*(15-c) = {~c, 2'b00}.
    sbox_lookup = word[{~col, 2'b00} +: 4];
  endfunction

  // All eight S-boxes, S1 output in the top nibble.
  function automatic logic [31:0] sbox_all(input logic [47:0] v);
    sbox_all = {sbox_lookup(3'd0, v[47:42]),
                sbox_lookup(3'd1, v[41:36]),
                sbox_lookup(3'd2, v[35:30]),
                sbox_lookup(3'd3, v[29:24]),
                sbox_lookup(3'd4, v[23:18]),
                sbox_lookup(3'd5, v[17:12]),
                sbox_lookup(3'd6, v[11:6]),
                sbox_lookup(3'd7, v[5:0])};
  endfunction

  // Permutation P: output DES bit i = input DES bit P[i]; with bit k of a
  // 32-bit bus at index 32-k this lists s[32-P[i]] for i = 1..32.
  function automatic logic [31:0] permute(input logic [31:0] s);
    permute = {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
               s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
               s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
               s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  logic        s1_valid;
  logic [47:0] x;
  logic [31:0] f_comb;
  logic        s1_free;   // whatever sits after stage 1 can take its entry
  logic        accept;
  logic        s1_leave;

  assign f_comb   = permute(sbox_all(x));
  assign in_ready = !s1_valid || s1_free;
  assign accept   = in_valid && in_ready;
  assign s1_leave = s1_valid && s1_free;

  // Stage 1: capture E(R) ^ K on accept; drop the valid bit once the entry moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      x        <= '0;
    end else begin
      if (accept) begin
        x        <= expand(r_in) ^ subkey;
        s1_valid <= 1'b1;
      end else if (s1_leave) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef DES_F_OUTREG_EN
  logic        s2_valid;
  logic [31:0] f_reg;

  assign s1_free   = !s2_valid || out_ready;
  assign out_valid = s2_valid;
  assign f_out     = f_reg;

  // Stage 2: register the f result whenever the output slot is free; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      f_reg    <= '0;
    end else if (s1_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        f_reg <= f_comb;
      end
    end
  end
`else
  // Single stage: the x register feeds the output through the S-box/P logic.
  assign s1_free   = out_ready;
  assign out_valid = s1_valid;
  assign f_out     = f_comb;
`endif

endmodule

// File: tb/tb_des_f_function.sv
// tb_des_f_function: randomized, self-checking bench for des_f_function.
// The reference computes f(R,K) from the DES tables with DES bit numbering
// and tracks in-flight results as a queue with ages. Honors DES_F_OUTREG_EN.
module tb_des_f_function;

`ifdef DES_F_OUTREG_EN
  localparam int          LAT     = 2;
  localparam int          CAP     = 2;
  localparam logic [31:0] RESET_F = 32'h00000000;
`else
  localparam int          LAT     = 1;
  localparam int          CAP     = 1;
  localparam logic [31:0] RESET_F = 32'hD8D8DBBC;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int dut_acc  = 0;
  int emit_cnt = 0;
  bit after_reset = 1'b1;

  logic [31:0] exp_q[$];
  int          age_q[$];

  des_f_function dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // DES tables in FIPS 46-3 order; S-box entry index = row*16 + col.
  int s_tab [0:7][0:63] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  int p_tab [0:31] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  // E computed arithmetically: output bit i belongs to group j, offset o,
  // and reads DES bit 4j+o (mod 32, 1-based).
  function automatic logic [47:0] ref_expand(input logic [31:0] r);
    logic [47:0] e;
    e = '0;
    for (int i = 1; i <= 48; i++) begin
      int j;
      int o;
      int src;
      j   = (i - 1) / 6;
      o   = (i - 1) % 6;
      src = ((4 * j + o - 1 + 32) % 32) + 1;
      e[48 - i] = r[32 - src];
    end
    return e;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] xv;
    logic [31:0] s;
    logic [31:0] p;
    xv = ref_expand(r) ^ k;
    s  = '0;
    for (int n = 0; n < 8; n++) begin
      int v;
      int row;
      int col;
      int nib;
      v   = int'((xv >> (42 - 6 * n)) & 48'h3F);
      row = ((v >> 4) & 2) | (v & 1);
      col = (v >> 1) & 15;
      nib = s_tab[n][row * 16 + col];
      s   = {s[27:0], nib[3:0]};
    end
    p = '0;
    for (int i = 1; i <= 32; i++) begin
      p[32 - i] = s[32 - p_tab[i - 1]];
    end
    return p;
  endfunction

  // One clock cycle: check outputs against the model, update the model, advance.
  // Entered at posedge+1 with inputs already driven.
  task automatic step();
    logic exp_ready;
    logic exp_valid;
    logic acc;
    logic emit;
    #1;
    exp_ready = (exp_q.size() < CAP) || out_ready;
    exp_valid = (exp_q.size() > 0) && (age_q[0] >= LAT);
    n_checks++;
    if (in_ready !== exp_ready) begin
      n_errors++;
      $display("FAIL in_ready cyc=%0d actual=%b expected=%b", cyc, in_ready, exp_ready);
    end
    n_checks++;
    if (out_valid !== exp_valid) begin
      n_errors++;
      $display("FAIL out_valid cyc=%0d actual=%b expected=%b", cyc, out_valid, exp_valid);
    end
    if (exp_valid) begin
      n_checks++;
      if (f_out !== exp_q[0]) begin
        n_errors++;
        $display("FAIL f_out cyc=%0d actual=%h expected=%h", cyc, f_out, exp_q[0]);
      end
    end else if (after_reset) begin
      n_checks++;
      if (f_out !== RESET_F) begin
        n_errors++;
        $display("FAIL f_out_reset cyc=%0d actual=%h expected=%h", cyc, f_out, RESET_F);
      end
    end
    if (!rst && in_valid && in_ready) dut_acc++;
    acc  = in_valid && exp_ready && !rst;
    emit = out_ready && exp_valid && !rst;
    if (rst) begin
      exp_q.delete();
      age_q.delete();
      after_reset = 1'b1;
    end else begin
      if (emit) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        emit_cnt++;
      end
      foreach (age_q[i]) age_q[i]++;
      if (acc) begin
        exp_q.push_back(ref_f(r_in, subkey));
        age_q.push_back(1);
        after_reset = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_random();
    r_in   = $urandom;
    subkey = {16'($urandom), 32'($urandom)};
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  // Single vector: measure latency to out_valid and compare with a known constant.
  task automatic single_vector(input logic [31:0] r, input logic [47:0] k,
                               input logic [31:0] known, input string name);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    r_in      = r;
    subkey    = k;
    step();
    in_valid  = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != LAT) begin
      n_errors++;
      $display("FAIL %s_latency actual=%0d expected=%0d", name, lat, LAT);
    end
    n_checks++;
    if (f_out !== known) begin
      n_errors++;
      $display("FAIL %s_value actual=%h expected=%h", name, f_out, known);
    end
    drain();
  endtask

  task automatic test_zero_vector();
    single_vector(32'h00000000, 48'h000000000000, 32'hD8D8DBBC, "zero");
  endtask

  task automatic test_fips_vector();
    single_vector(32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h234AA9BB, "fips");
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = emit_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      drive_random();
      step();
    end
    drain();
    n_checks++;
    if (emit_cnt - e0 != 16) begin
      n_errors++;
      $display("FAIL b2b_count actual=%0d expected=16", emit_cnt - e0);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    int e0;
    out_ready = 1'b0;
    a0 = dut_acc;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      drive_random();
      step();
    end
    n_checks++;
    if (dut_acc - a0 != CAP) begin
      n_errors++;
      $display("FAIL bp_accepts actual=%0d expected=%0d", dut_acc - a0, CAP);
    end
    e0 = emit_cnt;
    drain();
    n_checks++;
    if (emit_cnt - e0 != CAP) begin
      n_errors++;
      $display("FAIL bp_outputs actual=%0d expected=%0d", emit_cnt - e0, CAP);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < CAP + 1; i++) begin
      in_valid = 1'b1;
      drive_random();
      step();
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f_out !== RESET_F) begin
      n_errors++;
      $display("FAIL midreset actual=%b/%b/%h expected=0/1/%h", out_valid, in_ready, f_out, RESET_F);
    end
    repeat (6) step();
  endtask

  task automatic test_sbox_sweep();
    logic [31:0] r;
    logic [47:0] k;
    logic [47:0] e;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int v = 0; v < 64; v++) begin
        r = $urandom;
        k = {16'($urandom), 32'($urandom)};
        e = ref_expand(r);
        k[47 - 6 * n -: 6] = e[47 - 6 * n -: 6] ^ 6'(v);
        r_in     = r;
        subkey   = k;
        in_valid = 1'b1;
        step();
      end
    end
    drain();
  endtask

  task automatic test_random_flow();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_random();
      step();
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    r_in      = '0;
    subkey    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_zero_vector();
    test_fips_vector();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sbox_sweep();
    test_random_flow();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
